// File: rtl/minv_pkg.sv
// Shared constants and FSM state type for the modular-inverse X1 register chain.
package minv_pkg;

  localparam int unsigned MINV_W      = 16;
  localparam int unsigned MINV_WORDS  = 16;
  localparam int unsigned MINV_FDEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    DRAIN = 2'd2
  } minv_state_e;

endpackage

// File: rtl/minv_rd_fifo.sv
// Small synchronous FIFO carrying {last, data} from the X1 capture point to the output bus.
// A push and a pop in the same cycle at full are both taken; occupancy stays the same.
module minv_rd_fifo #(
  parameter int unsigned DW    = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  // FIFO state registers; storage clears so the read port shows zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/minv_x1_reader.sv
// Unloads the 256-bit X1 chain by cyclic word rotation and streams the words, LSW first,
// onto a valid/ready bus through a small FIFO. A full pass restores the chain contents.
// Optional feature macro MINV_RD_CHK_EN: append an XOR checksum word, carrying dout_last.
module minv_x1_reader
  import minv_pkg::*;
#(
  parameter int unsigned W      = MINV_W,
  parameter int unsigned WORDS  = MINV_WORDS,
  parameter int unsigned FDEPTH = MINV_FDEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic [W-1:0] x1_word,
  output logic         x1_we,
  output logic         x1_sel_cyc,
  output logic         x1_sel_rs,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last
);

  localparam int unsigned CNT_W = $clog2(WORDS) + 1;
  localparam int unsigned FW    = W + 1;

  minv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MINV_RD_CHK_EN
  logic [W-1:0]     chk_q, chk_d;
`endif

  logic          push_c, pop_c, space_c;
  logic [W-1:0]  wdata_c;
  logic          wlast_c;
  logic [FW-1:0] rdata;
  logic          full, empty;

  minv_rd_fifo #(
    .DW    (FW),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata ({wlast_c, wdata_c}),
    .pop   (pop_c),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign pop_c      = !empty && dout_ready;
  assign space_c    = !full || pop_c;
  assign dout       = rdata[W-1:0];
  assign dout_last  = rdata[W] && !empty;
  assign dout_valid = !empty;
  assign busy       = busy_q;
  assign done       = done_q;
  assign x1_sel_cyc = 1'b1;
  assign x1_sel_rs  = 1'b0;

  // Pass sequencing: rotate one word per cycle while the FIFO can take it, then drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    push_c  = 1'b0;
    x1_we   = 1'b0;
    wdata_c = x1_word;
    wlast_c = 1'b0;
`ifdef MINV_RD_CHK_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROT;
          cnt_d   = '0;
`ifdef MINV_RD_CHK_EN
          chk_d   = '0;
`endif
        end
      end
      ROT: begin
        if (space_c) begin
`ifdef MINV_RD_CHK_EN
          if (cnt_q == CNT_W'(WORDS)) begin
            push_c  = 1'b1;
            wdata_c = chk_q;
            wlast_c = 1'b1;
            state_d = DRAIN;
          end else begin
            push_c = 1'b1;
            x1_we  = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            chk_d  = chk_q ^ x1_word;
          end
`else
          push_c  = 1'b1;
          x1_we   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          wlast_c = (cnt_q == CNT_W'(WORDS - 1));
          if (cnt_q == CNT_W'(WORDS - 1)) state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (pop_c && rdata[W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MINV_RD_CHK_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MINV_RD_CHK_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_minv_x1_reader.sv
// Scoreboard bench for minv_x1_reader with a behavioural model of the X1 rotation chain.
module tb_minv_x1_reader;

  localparam int W      = 16;
  localparam int WORDS  = 16;
  localparam int FDEPTH = 2;
`ifdef MINV_RD_CHK_EN
  localparam int NBEATS = WORDS + 1;
`else
  localparam int NBEATS = WORDS;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done;
  logic [W-1:0] x1_word;
  logic         x1_we, x1_sel_cyc, x1_sel_rs;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         dout_last;

  minv_x1_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .x1_word    (x1_word),
    .x1_we      (x1_we),
    .x1_sel_cyc (x1_sel_cyc),
    .x1_sel_rs  (x1_sel_rs),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  // X1 chain model: slice 0 leaves the chain, every slice takes its upper neighbour.
  logic [W-1:0] x1_mem [WORDS];
  logic [W-1:0] ld     [WORDS];
  logic         rot_pend = 1'b0;
  assign x1_word = x1_mem[0];

  always @(posedge clk) begin
    #1;
    if (rot_pend && x1_sel_cyc && !x1_sel_rs) begin
      logic [W-1:0] tmp;
      tmp = x1_mem[0];
      for (int i = 0; i < WORDS - 1; i++) x1_mem[i] = x1_mem[i + 1];
      x1_mem[WORDS - 1] = tmp;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [W:0] sbq[$];
  int  occ = 0, we_cnt = 0, beats = 0, done_cnt = 0;
  int  cyc_n = 0, last_cyc = 0, done_cyc = 0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] dout_prev = '0;

  // Monitor: scoreboard compare on each accepted beat, FIFO-full guard on x1_we.
  always @(negedge clk) begin
    logic pop;
    logic [W:0] exp;
    cyc_n++;
    if (!rst_n) begin
      occ = 0;
      rot_pend = 1'b0;
      hold_prev = 1'b0;
    end else begin
      pop = dout_valid && dout_ready;
      if (hold_prev && dout_valid) begin
        checks++;
        if (dout !== dout_prev) begin
          errors++;
          $display("FAIL dout_stable actual=%h required=%h", dout, dout_prev);
        end
      end
      if (x1_we) begin
        checks++;
        we_cnt++;
        if (!(occ < FDEPTH || pop)) begin
          errors++;
          $display("FAIL we_at_full actual occ=%0d required below %0d", occ, FDEPTH);
        end
      end
      if (pop) begin
        beats++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h required=no beat", {dout_last, dout});
        end else begin
          exp = sbq.pop_front();
          if ({dout_last, dout} !== exp) begin
            errors++;
            $display("FAIL beat%0d actual last=%b data=%h required last=%b data=%h",
                     beats - 1, dout_last, dout, exp[W], exp[W-1:0]);
          end
        end
        if (dout_last) last_cyc = cyc_n;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      occ = occ + int'(x1_we) - int'(pop);
      rot_pend = x1_we;
      hold_prev = dout_valid && !dout_ready;
      dout_prev = dout;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic load(input logic [W-1:0] base);
    for (int i = 0; i < WORDS; i++) begin
      ld[i]     = base + W'(i);
      x1_mem[i] = base + W'(i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(done), 0);
    chk({tag, "_we"},     32'(x1_we), 0);
    chk({tag, "_selcyc"}, 32'(x1_sel_cyc), 1);
    chk({tag, "_selrs"},  32'(x1_sel_rs), 0);
    chk({tag, "_dout"},   32'(dout), 0);
    chk({tag, "_valid"},  32'(dout_valid), 0);
    chk({tag, "_last"},   32'(dout_last), 0);
  endtask

  task automatic push_expected(input logic [W-1:0] chk_word);
    for (int i = 0; i < WORDS; i++)
      sbq.push_back({(NBEATS == WORDS) && (i == WORDS - 1), ld[i]});
    if (NBEATS != WORDS) sbq.push_back({1'b1, chk_word});
  endtask

  // One unload pass; mode 0 = ready high, 1 = ready toggling; optional stall and re-start.
  task automatic run_pass(input string nm, input int mode, input int stall, input bit restart,
                          input logic [W-1:0] chk_word);
    bit rs_done = 0;
    occ = 0; we_cnt = 0; beats = 0; done_cnt = 0;
    push_expected(chk_word);
    start = 1'b1;
    dout_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 1);
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      dout_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (c < stall) dout_ready = 1'b0;
      if (stall > 0 && c == stall) chk({nm, "_stall_we"}, 32'(we_cnt), FDEPTH);
      if (restart && !rs_done && beats >= 5) begin
        start = 1'b1;
        rs_done = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    dout_ready = 1'b1;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no done required=done", nm);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, 32'(done_cnt), 1);
    chk({nm, "_beats"},    32'(beats), 32'(NBEATS));
    chk({nm, "_sb_left"},  32'(sbq.size()), 0);
    chk({nm, "_done_lat"}, 32'(done_cyc - last_cyc), 1);
    chk({nm, "_we_cnt"},   32'(we_cnt), 32'(WORDS));
    chk({nm, "_idle"},     32'(busy), 0);
    for (int i = 0; i < WORDS; i++) chk({nm, "_x1"}, 32'(x1_mem[i]), 32'(ld[i]));
  endtask

  initial begin
    load(16'h0000);
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Streaming, toggling backpressure, long stall, ignored second start.
    run_pass("s1", 0, 0, 0, 16'h0000);
    run_pass("s2", 1, 0, 0, 16'h0000);
    run_pass("s3", 0, 10, 0, 16'h0000);
    run_pass("s4", 0, 0, 1, 16'h0000);

    // Reset in the middle of a pass, then reload and unload again.
    push_expected(16'h0000);
    start = 1'b1;
    dout_ready = 1'b1;
    beats = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && beats < 7; c++) begin
      @(posedge clk); #1;
    end
    chk("s5_reached_word7", 32'(beats), 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_async");
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(16'h0000);
    @(posedge clk); #1;
    run_pass("s5", 0, 0, 0, 16'h0000);

    // Words 0x0001..0x0010: XOR of the data is 0x0010.
    load(16'h0001);
    run_pass("s6", 0, 0, 0, 16'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
